encoder_8to3_sync: RTL and testbench

ENCODER_8TO3_SYNC -- requirements
Module: encoder_8to3_sync

---
 rtl/encoder_8to3_sync.sv | 80 ++++++++
 tb/tb_encoder_8to3_sync.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_8to3_sync.sv
// Registered 8-to-3 priority encoder with a pending-request register and valid/ready delivery.
// Define ENCODER_OVF_EN to add the sticky ovf output for requests that land on an already-pending bit.
module encoder_8to3_sync (
    input  logic clk,
    input  logic rst,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    input  logic ready,
    output logic a,
    output logic b,
    output logic c,
    output logic valid,
    output logic idle
`ifdef ENCODER_OVF_EN
    ,
    output logic ovf
`endif
);

    logic [7:0] d;
    logic [7:0] pending;
    logic [7:0] clear_mask;
    logic [2:0] code;
    logic [2:0] sel;
    logic       handshake;
    logic       load;

    assign d         = {d7, d6, d5, d4, d3, d2, d1, d0};
    assign handshake = valid & ready;
    assign load      = (~valid | handshake) & (|pending);

    // Ascending scan, so the highest set bit is the one that sticks.
    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) begin
                sel = i[2:0];
            end
        end
    end

    assign clear_mask = load ? (8'b1 << sel) : 8'h00;

    // OR-ing d in after the clear lets a fresh request win over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 8'h00;
            code    <= 3'b000;
            valid   <= 1'b0;
        end else begin
            pending <= (pending & ~clear_mask) | d;
            if (load) begin
                code  <= sel;
                valid <= 1'b1;
            end else if (handshake) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef ENCODER_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (|(d & pending & ~clear_mask)) begin
            ovf <= 1'b1;
        end
    end
`endif

    assign {a, b, c} = code;
    assign idle      = ~valid & ~(|pending);

endmodule

// File: tb/tb_encoder_8to3_sync.sv
// Self-checking bench for encoder_8to3_sync: directed scenarios plus randomized traffic
// compared against a per-cycle behavioural model of the pending/valid/ready rules.
module tb_encoder_8to3_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic [7:0] d;
    logic       a, b, c, valid, idle;
`ifdef ENCODER_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int passed = 0;

    // behavioural model state
    bit [7:0] m_pend;
    bit       m_valid;
    int       m_code;
    bit       m_ovf;

    encoder_8to3_sync dut (
        .clk   (clk),
        .rst   (rst),
        .d0    (d[0]),
        .d1    (d[1]),
        .d2    (d[2]),
        .d3    (d[3]),
        .d4    (d[4]),
        .d5    (d[5]),
        .d6    (d[6]),
        .d7    (d[7]),
        .ready (ready),
        .a     (a),
        .b     (b),
        .c     (c),
        .valid (valid),
        .idle  (idle)
`ifdef ENCODER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        d     = 8'h00;
        ready = 1'b0;
        tick();
        rst   = 1'b0;
    endtask

    task automatic model_reset();
        m_pend  = 8'h00;
        m_valid = 1'b0;
        m_code  = 0;
        m_ovf   = 1'b0;
    endtask

    // One rising edge of the model: inputs are those held before the edge.
    task automatic model_step(input bit [7:0] din, input bit rdy);
        bit hs;
        bit do_load;
        int top;
        hs      = m_valid && rdy;
        do_load = (!m_valid || hs) && (m_pend != 0);
        top     = -1;
        for (int i = 7; i >= 0; i--) begin
            if (m_pend[i] && top < 0) top = i;
        end
        for (int i = 0; i < 8; i++) begin
            if (din[i] && m_pend[i] && !(do_load && i == top)) m_ovf = 1'b1;
        end
        if (do_load) begin
            m_code       = top;
            m_valid      = 1'b1;
            m_pend[top]  = 1'b0;
        end else if (hs) begin
            m_valid = 1'b0;
        end
        m_pend = m_pend | din;
    endtask

    task automatic test_reset();
        rst = 1'b1; d = 8'hFF; ready = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || {a, b, c} !== 3'b000 || idle !== 1'b1)
            $display("FAIL reset_state: valid=%b code=%b idle=%b, want 0 000 1", valid, {a, b, c}, idle);
        else passed++;
        tick();
        rst = 1'b0; d = 8'h00; ready = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        ready = 1'b1; d = 8'h20;
        tick();
        d = 8'h00;
        checks++;
        if (valid !== 1'b0) $display("FAIL single_latency1: valid=%b, want 0", valid);
        else passed++;
        tick();
        checks++;
        if (valid !== 1'b1 || {a, b, c} !== 3'b101)
            $display("FAIL single_deliver: valid=%b code=%b, want 1 101", valid, {a, b, c});
        else passed++;
        tick();
        checks++;
        if (valid !== 1'b0 || idle !== 1'b1 || {a, b, c} !== 3'b101)
            $display("FAIL single_after: valid=%b idle=%b code=%b, want 0 1 101", valid, idle, {a, b, c});
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit [2:0] exp_codes [3] = '{3'b110, 3'b011, 3'b000};
        do_reset();
        ready = 1'b1; d = 8'h49;
        tick();
        d = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || {a, b, c} !== exp_codes[i])
                $display("FAIL b2b_code%0d: valid=%b code=%b, want 1 %b", i, valid, {a, b, c}, exp_codes[i]);
            else passed++;
        end
        tick();
        checks++;
        if (valid !== 1'b0 || idle !== 1'b1)
            $display("FAIL b2b_drain: valid=%b idle=%b, want 0 1", valid, idle);
        else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        ready = 1'b0; d = 8'h04;
        tick();
        d = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || {a, b, c} !== 3'b010)
                $display("FAIL stall_hold%0d: valid=%b code=%b, want 1 010", i, valid, {a, b, c});
            else passed++;
        end
        d = 8'h80;
        tick();
        d = 8'h00;
        tick();
        checks++;
        if (valid !== 1'b1 || {a, b, c} !== 3'b010)
            $display("FAIL stall_after_d7: valid=%b code=%b, want 1 010", valid, {a, b, c});
        else passed++;
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || {a, b, c} !== 3'b111)
            $display("FAIL stall_d7: valid=%b code=%b, want 1 111", valid, {a, b, c});
        else passed++;
        tick();
        checks++;
        if (valid !== 1'b0 || {a, b, c} !== 3'b111)
            $display("FAIL stall_drain: valid=%b code=%b, want 0 111", valid, {a, b, c});
        else passed++;
    endtask

    task automatic test_hold();
        do_reset();
        ready = 1'b1; d = 8'h10;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || {a, b, c} !== 3'b100)
                $display("FAIL hold_cycle%0d: valid=%b code=%b, want 1 100", i, valid, {a, b, c});
            else passed++;
        end
        d = 8'h00;
        tick();
        tick();
        checks++;
        if (valid !== 1'b0 || idle !== 1'b1)
            $display("FAIL hold_drain: valid=%b idle=%b, want 0 1", valid, idle);
        else passed++;
    endtask

    task automatic test_merge();
        int deliveries;
        do_reset();
        ready = 1'b0; d = 8'h80;
        tick();
        d = 8'h00;
        tick();
        d = 8'h02; tick();
        d = 8'h00; tick();
        d = 8'h02; tick();
        d = 8'h00; tick();
`ifdef ENCODER_OVF_EN
        checks++;
        if (ovf !== 1'b1) $display("FAIL merge_ovf_set: ovf=%b, want 1", ovf);
        else passed++;
`endif
        ready = 1'b1;
        deliveries = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid === 1'b1 && {a, b, c} === 3'b001) deliveries++;
        end
        checks++;
        if (deliveries != 1) $display("FAIL merge_single: deliveries of 001=%0d, want 1", deliveries);
        else passed++;
`ifdef ENCODER_OVF_EN
        checks++;
        if (ovf !== 1'b1) $display("FAIL merge_ovf_sticky: ovf=%b, want 1", ovf);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (ovf !== 1'b0) $display("FAIL merge_ovf_reset: ovf=%b, want 0", ovf);
        else passed++;
        tick();
        rst = 1'b0;
`endif
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        ready = 1'b0; d = 8'h80;
        tick();
        d = 8'h00;
        tick();
        d = 8'h0C;
        tick();
        d = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || {a, b, c} !== 3'b000 || idle !== 1'b1)
            $display("FAIL reset_mid: valid=%b code=%b idle=%b, want 0 000 1", valid, {a, b, c}, idle);
        else passed++;
        tick();
        rst = 1'b0; ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) $display("FAIL reset_mid_after: cycles with valid after release=%0d, want 0", seen);
        else passed++;
    endtask

    task automatic test_random();
        bit [7:0] din;
        bit       rdy;
        int       errs;
        do_reset();
        model_reset();
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            din   = 8'($urandom) & 8'($urandom) & 8'($urandom);
            rdy   = ($urandom_range(0, 3) != 0);
            d     = din;
            ready = rdy;
            tick();
            model_step(din, rdy);
            checks++;
            if (valid !== m_valid || idle !== (!m_valid && m_pend == 0) ||
                (m_valid && {a, b, c} !== 3'(m_code))
`ifdef ENCODER_OVF_EN
                || ovf !== m_ovf
`endif
               ) begin
                if (errs < 10)
                    $display("FAIL random_cycle%0d: valid=%b code=%b idle=%b, want %b %b %b",
                             n, valid, {a, b, c}, idle, m_valid, 3'(m_code), (!m_valid && m_pend == 0));
                errs++;
            end else passed++;
        end
        d = 8'h00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_hold();
        test_merge();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
